hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W). It sits beside the decode/execute/memory pipeline registers and generates their stall/flush enables and the execute-stage operand forwarding selects. It also sequences multi-cycle data-memory accesses with a wait/timeout state machine, and halts the pipeline on a memory timeout.

Parameters:
MEM_TIMEOUT, 16, maximum cycles in WAIT before declaring a memory error (legal range 2..255)
CNT_W, 8, width of the wait-cycle counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
rs1_d  input  5  decode-stage source register 1
rs2_d  input  5  decode-stage source register 2
rs1_e  input  5  execute-stage source register 1
rs2_e  input  5  execute-stage source register 2
rd_e  input  5  execute-stage destination register
regwrite_e  input  1  execute-stage instruction writes the register file
resultsrc_e  input  1  execute-stage instruction is a load
pcsrc_e  input  1  branch/jump taken in execute
rd_m  input  5  memory-stage destination register
regwrite_m  input  1  memory-stage register write
mem_req_m  input  1  memory stage holds a load/store
mem_ready_m  input  1  data memory has completed the access this cycle
rd_w  input  5  writeback-stage destination register
regwrite_w  input  1  writeback-stage register write
stall_f  output  1  hold PC
stall_d  output  1  hold F/D register
stall_e  output  1  hold D/E register
stall_m  output  1  hold E/M register
flush_d  output  1  clear F/D register
flush_e  output  1  clear D/E register (insert bubble)
flush_w  output  1  clear M/W register (bubble into W)
fwd_a_e  output  2  rs1 operand select: 00 = register file, 01 = W result, 10 = M ALU result
fwd_b_e  output  2  rs2 operand select, same encoding
mem_err  output  1  sticky memory-timeout flag

Behaviour:
- Reset: rst low forces FSM to RUN, wait_cnt to 0 and mem_err to 0. All stall, flush and fwd outputs are 0 while rst is low, regardless of inputs.
- Forwarding (combinational, every state):
  - fwd_a_e = 10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
  - Otherwise fwd_a_e = 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e.
  - Otherwise fwd_a_e = 00.
  - fwd_b_e is identical, using rs2_e.
  - M has priority over W. x0 is never forwarded.
- Hazard terms:
  - mw = mem_req_m && !mem_ready_m
  - lu = resultsrc_e && regwrite_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d)
- FSM states: RUN, WAIT, HALT. Outputs are Mealy; the register update happens on the clk edge.
- RUN, priority mw > pcsrc_e > lu:
  - mw: stall_f=stall_d=stall_e=stall_m=1, flush_w=1. Next state WAIT, wait_cnt<=1. pcsrc_e and lu are ignored: E is frozen, so they re-evaluate after the wait.
  - else pcsrc_e: flush_d=flush_e=1, no stalls. A concurrent lu is discarded because the dependent instruction is squashed.
  - else lu: stall_f=stall_d=1, flush_e=1. This is a one-cycle bubble; next cycle lu is false since the load is then in M.
  - else all outputs 0.
- WAIT:
  - mem_ready_m=1: outputs as RUN with mw=0, evaluated in the same cycle (zero-cycle release). Next state RUN, wait_cnt<=0.
  - mem_ready_m=0 and wait_cnt==MEM_TIMEOUT-1: four stalls + flush_w. Next state HALT, mem_err<=1.
  - Otherwise: four stalls + flush_w, wait_cnt<=wait_cnt+1.
- HALT: stall_f/d/e/m=1, flush_w=1, flushes d/e=0. All inputs are ignored and mem_err holds at 1. Only rst exits HALT.
- Reset asserted mid-WAIT or in HALT: immediate return to RUN with the counter cleared. No pulse on any output.
- A stall and a flush are never asserted on the same pipeline register in the same cycle.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0], both reset to 0.
  - stall_cycles increments each cycle stall_f=1.
  - flush_events increments each cycle flush_d=1.
  - Both wrap modulo 2^32 and hold in HALT.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- M forwarding: regwrite_m=1, rd_m=5, rs1_e=5, plus regwrite_w=1, rd_w=5, rs2_e=5 -> fwd_a_e=10, fwd_b_e=01. Then rd_m=0, rs1_e=0 -> fwd_a_e=00.
- Load-use: resultsrc_e=1, regwrite_e=1, rd_e=7, rs2_d=7 -> exactly one cycle of stall_f=stall_d=flush_e=1. Next cycle rd_e cleared, so all outputs 0.
- Branch vs load-use: same as previous plus pcsrc_e=1 -> flush_d=flush_e=1, stall_f=0, stall_d=0.
- Memory wait: mem_req_m=1, mem_ready_m=0 for 3 cycles, then ready -> stalls + flush_w high for 3 cycles, low in the ready cycle, mem_err=0.
- Timeout: MEM_TIMEOUT=4, ready never -> mem_err rises on the edge after the 4th stalled cycle and stays 1. Stalls persist; pcsrc_e=1 is ignored.
- Reset: assert rst low during HALT -> all outputs 0 immediately. After release the FSM is in RUN, and a fresh load-use case behaves as in the load-use scenario.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage RV32I core.
//
// Produces the stall/flush enables for the F/D/E/M pipeline registers and
// the execute-stage forwarding selects. Also sequences multi-cycle data
// memory accesses:
//   RUN  -> WAIT when memory is busy.
//   WAIT -> RUN when memory is ready.
//   WAIT -> HALT after MEM_TIMEOUT stalled cycles, which raises mem_err.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   rs1_d, rs2_d             decode-stage source registers
//   rs1_e, rs2_e, rd_e       execute-stage sources / destination
//   regwrite_e, resultsrc_e  execute-stage write enable / is-load
//   pcsrc_e                  branch/jump taken in execute
//   rd_m, regwrite_m         memory-stage destination / write enable
//   mem_req_m, mem_ready_m   memory-stage access request / completion
//   rd_w, regwrite_w         writeback-stage destination / write enable
//   stall_f/d/e/m            hold PC, F/D, D/E, E/M
//   flush_d/e/w              clear F/D, D/E, M/W
//   fwd_a_e, fwd_b_e         operand selects (00 regfile, 01 W, 10 M)
//   mem_err                  sticky memory-timeout flag
//
// Optional build macro HAZARD_PERF_CNT_EN adds two extra ports:
//   stall_cycles  counts cycles with stall_f asserted (frozen in HALT)
//   flush_events  counts cycles with flush_d asserted
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic       regwrite_e,
  input  logic       resultsrc_e,
  input  logic       pcsrc_e,
  input  logic [4:0] rd_m,
  input  logic       regwrite_m,
  input  logic       mem_req_m,
  input  logic       mem_ready_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_w,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic mw_s;       // memory stage busy
  logic lu_s;       // load-use dependency between E and D
  logic hold_s;     // freeze the pipeline and bubble W
  logic release_s;  // normal branch / load-use handling applies

  // Forwarding select: M result beats W result; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m,
                                         input logic [4:0] dst_m,
                                         input logic       wr_w,
                                         input logic [4:0] dst_w);
    logic [1:0] sel;
    if (wr_m && (dst_m != 5'd0) && (dst_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (dst_w != 5'd0) && (dst_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard terms.
  always_comb begin
    mw_s = mem_req_m && !mem_ready_m;
    lu_s = resultsrc_e && regwrite_e && (rd_e != 5'd0) &&
           ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

  // Next-state logic; classifies the cycle as hold or release.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    hold_s     = 1'b0;
    release_s  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mw_s) begin
          hold_s     = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = CNT_ONE;
        end else begin
          release_s = 1'b1;
        end
      end
      S_WAIT: begin
        // Zero-cycle release: the ready cycle is handled as a RUN cycle.
        if (mem_ready_m) begin
          release_s  = 1'b1;
          state_d    = S_RUN;
          wait_cnt_d = {CNT_W{1'b0}};
        end else if (wait_cnt_q == CNT_LAST) begin
          hold_s    = 1'b1;
          state_d   = S_HALT;
          mem_err_d = 1'b1;
        end else begin
          hold_s     = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      S_HALT: begin
        hold_s = 1'b1;
      end
      default: begin
        // Unreachable encoding: freeze the pipeline and recover to RUN.
        hold_s     = 1'b1;
        state_d    = S_RUN;
        wait_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Mealy stall/flush/forward outputs.
  // All outputs are forced low while reset is held.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (rst) begin
      fwd_a_e = fwd_sel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
      fwd_b_e = fwd_sel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
      if (hold_s) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (release_s && pcsrc_e) begin
        // A taken branch squashes the dependent instruction,
        // so a concurrent load-use is dropped.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (release_s && lu_s) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        stall_f = 1'b0;
      end
    end else begin
      stall_f = 1'b0;
    end
  end

  // FSM state, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= {CNT_W{1'b0}};
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Performance counter increments.
  // The stall counter is frozen while HALT is reached.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stall_f && (state_q != S_HALT)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (flush_d) begin
      flush_events_d = flush_events_q + 32'd1;
    end else begin
      flush_events_d = flush_events_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// The bench applies three kinds of stimulus:
//   - a table of directed vectors,
//   - hand-written multi-cycle sequences (memory wait, timeout, reset in HALT),
//   - randomized cycles checked against a behavioural reference model.
// The DUT is built with MEM_TIMEOUT=4.
module tb_hazard_ctrl;

  localparam int TMO = 4;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic regwrite_e, resultsrc_e, pcsrc_e, regwrite_m, mem_req_m, mem_ready_m, regwrite_w;
  } in_t;

  typedef struct packed {
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  in_t  cur = '0;
  out_t act;

  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
  logic [1:0] fwd_a_e, fwd_b_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  // mode: 0 running, 1 waiting on memory, 2 halted.
  int m_mode    = 0;
  int m_stalled = 0;  // stalled cycles spent on the current access
  bit m_err     = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(cur.rs1_d), .rs2_d(cur.rs2_d), .rs1_e(cur.rs1_e), .rs2_e(cur.rs2_e),
    .rd_e(cur.rd_e), .regwrite_e(cur.regwrite_e), .resultsrc_e(cur.resultsrc_e),
    .pcsrc_e(cur.pcsrc_e), .rd_m(cur.rd_m), .regwrite_m(cur.regwrite_m),
    .mem_req_m(cur.mem_req_m), .mem_ready_m(cur.mem_ready_m),
    .rd_w(cur.rd_w), .regwrite_w(cur.regwrite_w),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err)
  );

  always_comb act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                     fwd_a_e, fwd_b_e, mem_err};

  // flags = {regwrite_e, resultsrc_e, pcsrc_e, regwrite_m, mem_req_m, mem_ready_m, regwrite_w}
  function automatic in_t mk_in(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input logic [6:0] flags);
    return {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, flags};
  endfunction

  // st = {f,d,e,m}, fl = {d,e,w}
  function automatic out_t mk_out(input logic [3:0] st, input logic [2:0] fl,
                                  input logic [1:0] fa, fb, input logic err);
    return {st, fl, fa, fb, err};
  endfunction

  function automatic logic [1:0] ref_fwd(input in_t i, input logic [4:0] rs);
    if (i.regwrite_m && i.rd_m != 5'd0 && i.rd_m == rs) return 2'b10;
    if (i.regwrite_w && i.rd_w != 5'd0 && i.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input in_t i, input logic r);
    out_t o;
    bit mw, lu, frozen;
    o = '0;
    if (r) begin
      o.fwd_a = ref_fwd(i, i.rs1_e);
      o.fwd_b = ref_fwd(i, i.rs2_e);
      mw = i.mem_req_m && !i.mem_ready_m;
      lu = i.resultsrc_e && i.regwrite_e && i.rd_e != 5'd0 &&
           (i.rd_e == i.rs1_d || i.rd_e == i.rs2_d);
      frozen = (m_mode == 2) || (m_mode == 0 && mw) || (m_mode == 1 && !i.mem_ready_m);
      if (frozen) begin
        o.stall_f = 1'b1; o.stall_d = 1'b1; o.stall_e = 1'b1; o.stall_m = 1'b1;
        o.flush_w = 1'b1;
      end else if (i.pcsrc_e) begin
        o.flush_d = 1'b1; o.flush_e = 1'b1;
      end else if (lu) begin
        o.stall_f = 1'b1; o.stall_d = 1'b1; o.flush_e = 1'b1;
      end
      o.mem_err = m_err;
    end
    return o;
  endfunction

  task automatic model_step(input in_t i, input logic r);
    if (!r) begin
      m_mode = 0; m_stalled = 0; m_err = 1'b0;
    end else if (m_mode == 0) begin
      if (i.mem_req_m && !i.mem_ready_m) begin
        m_mode = 1; m_stalled = 1;
      end
    end else if (m_mode == 1) begin
      if (i.mem_ready_m) begin
        m_mode = 0; m_stalled = 0;
      end else if (m_stalled + 1 == TMO) begin
        m_mode = 2; m_err = 1'b1;
      end else begin
        m_stalled = m_stalled + 1;
      end
    end
  endtask

  // Drive one cycle at the falling edge, compare against exp, then advance the model.
  task automatic apply(input in_t i, input logic r, input out_t exp, input string name);
    @(negedge clk);
    rst = r;
    cur = i;
    #1;
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
    model_step(i, r);
  endtask

  vec_t tbl[10];
  in_t  lu_in, busy_in, rdy_in, idle_in, ri;
  logic rr;

  initial begin
    // Directed table; every vector stays in the running mode (no busy memory).
    tbl[0] = {mk_in(0,0,5,6,0,5,6, 7'b0001001), mk_out(4'b0000,3'b000,2'b10,2'b01,1'b0)};
    tbl[1] = {mk_in(0,0,5,5,0,5,5, 7'b0001001), mk_out(4'b0000,3'b000,2'b10,2'b10,1'b0)};
    tbl[2] = {mk_in(0,0,0,0,0,0,0, 7'b0001001), mk_out(4'b0000,3'b000,2'b00,2'b00,1'b0)};
    tbl[3] = {mk_in(0,0,9,3,0,9,9, 7'b0000001), mk_out(4'b0000,3'b000,2'b01,2'b00,1'b0)};
    tbl[4] = {mk_in(1,7,0,0,7,0,0, 7'b1100000), mk_out(4'b1100,3'b010,2'b00,2'b00,1'b0)};
    tbl[5] = {mk_in(0,0,0,0,0,0,0, 7'b1100000), mk_out(4'b0000,3'b000,2'b00,2'b00,1'b0)};
    tbl[6] = {mk_in(1,7,0,0,7,0,0, 7'b1110000), mk_out(4'b0000,3'b110,2'b00,2'b00,1'b0)};
    tbl[7] = {mk_in(7,7,0,0,7,0,0, 7'b1000000), mk_out(4'b0000,3'b000,2'b00,2'b00,1'b0)};
    tbl[8] = {mk_in(0,0,0,0,0,0,0, 7'b0010000), mk_out(4'b0000,3'b110,2'b00,2'b00,1'b0)};
    tbl[9] = {mk_in(3,0,0,0,3,0,0, 7'b1100110), mk_out(4'b1100,3'b010,2'b00,2'b00,1'b0)};

    lu_in   = mk_in(1,7,0,0,7,0,0, 7'b1100000);
    busy_in = mk_in(0,0,0,0,0,0,0, 7'b0000100);
    rdy_in  = mk_in(0,0,0,0,0,0,0, 7'b0000110);
    idle_in = '0;

    // Reset state: everything low while rst is held, whatever the inputs.
    apply(mk_in(1,7,5,5,7,5,5, 7'b1111101), 1'b0, '0, "reset_state");
    apply(idle_in, 1'b0, '0, "reset_hold");

    foreach (tbl[k]) apply(tbl[k].i, 1'b1, tbl[k].o, $sformatf("table_%0d", k));

    // Memory wait: three busy cycles, then ready (released in the same cycle).
    for (int k = 0; k < 3; k++)
      apply(busy_in, 1'b1, mk_out(4'b1111,3'b001,2'b00,2'b00,1'b0), $sformatf("memwait_%0d", k));
    apply(rdy_in, 1'b1, '0, "memwait_release");
    apply(idle_in, 1'b1, '0, "memwait_after");

    // Busy for one cycle, then the ready cycle also carries a taken branch.
    apply(busy_in, 1'b1, mk_out(4'b1111,3'b001,2'b00,2'b00,1'b0), "memwait2_busy");
    ri = rdy_in; ri.pcsrc_e = 1'b1;
    apply(ri, 1'b1, mk_out(4'b0000,3'b110,2'b00,2'b00,1'b0), "memwait2_release_branch");

    // Timeout: four stalled cycles, then mem_err is set and HALT ignores all inputs.
    for (int k = 0; k < TMO; k++)
      apply(busy_in, 1'b1, mk_out(4'b1111,3'b001,2'b00,2'b00,1'b0), $sformatf("timeout_stall_%0d", k));
    ri = busy_in; ri.pcsrc_e = 1'b1;
    apply(ri, 1'b1, mk_out(4'b1111,3'b001,2'b00,2'b00,1'b1), "halt_branch_ignored");
    ri = rdy_in; ri.pcsrc_e = 1'b1;
    apply(ri, 1'b1, mk_out(4'b1111,3'b001,2'b00,2'b00,1'b1), "halt_ready_ignored");
    apply(lu_in, 1'b1, mk_out(4'b1111,3'b001,2'b00,2'b00,1'b1), "halt_sticky");

    // Reset in HALT: outputs drop at once; afterwards load-use behaves normally.
    apply(lu_in, 1'b0, '0, "halt_reset");
    apply(lu_in, 1'b1, mk_out(4'b1100,3'b010,2'b00,2'b00,1'b0), "post_reset_loaduse");
    apply(idle_in, 1'b1, '0, "post_reset_clear");

    // Randomized cycles against the reference model.
    for (int k = 0; k < 400; k++) begin
      ri.rs1_d = 5'($urandom_range(0, 3));
      ri.rs2_d = 5'($urandom_range(0, 3));
      ri.rs1_e = 5'($urandom_range(0, 3));
      ri.rs2_e = 5'($urandom_range(0, 3));
      ri.rd_e  = 5'($urandom_range(0, 3));
      ri.rd_m  = 5'($urandom_range(0, 3));
      ri.rd_w  = 5'($urandom_range(0, 3));
      ri.regwrite_e  = 1'($urandom);
      ri.resultsrc_e = 1'($urandom);
      ri.pcsrc_e     = ($urandom_range(0, 3) == 0);
      ri.regwrite_m  = 1'($urandom);
      ri.mem_req_m   = 1'($urandom);
      ri.mem_ready_m = 1'($urandom);
      ri.regwrite_w  = 1'($urandom);
      rr = ($urandom_range(0, 29) != 0);
      apply(ri, rr, model_out(ri, rr), $sformatf("random_%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
